hgw_unsat_expand: RTL and testbench

Receive-side companion to the unsigned saturator. Takes a narrowed, saturated unsigned sample stream and widens it back to the wide datapath width. Each sample equal to narrow full-scale (all ones) is flagged as clipped. The block keeps a saturating clip counter and raises a sticky alarm when clipping runs for too long. It sits after the narrow link, behind a valid/ready handshake, and feeds the wide processing chain.

---
 rtl/hgw_unsat_expand_if.sv | 58 +++++
 rtl/hgw_unsat_expand.sv | 152 +++++++++++++++
 tb/tb_hgw_unsat_expand.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hgw_unsat_expand_if.sv
// ----------------------------------------------------------------------------
// hgw_unsat_expand_if
//
// Purpose: bundles the narrow input stream and the wide output stream of
// hgw_unsat_expand into one interface so the block and its bench share a
// single declaration of the data path signals.
//
// Handshake semantics (both streams): a transfer happens on a rising clock
// edge where valid and ready are both high. Once valid is raised it stays
// high, and the payload stays stable, until that transfer happens. Ready may
// depend combinationally on the downstream ready, but never on valid.
//
// Signals:
//   i_vld  : narrow sample valid            (master -> slave)
//   i_rdy  : block can take a sample        (slave  -> master)
//   i_dat  : narrow unsigned sample, I_W    (master -> slave)
//   o_vld  : widened sample valid           (slave  -> master)
//   o_rdy  : downstream can take a sample   (master -> slave)
//   o_dat  : widened sample, O_W            (slave  -> master)
//   o_clip : sample on o_dat was clipped    (slave  -> master)
//
// Modports:
//   master : the environment around the block (drives input stream, sinks
//            the output stream)
//   slave  : the expander itself
// ----------------------------------------------------------------------------
interface hgw_unsat_expand_if #(
    parameter int I_W = 15,
    parameter int O_W = 16
);
    logic           i_vld;
    logic           i_rdy;
    logic [I_W-1:0] i_dat;
    logic           o_vld;
    logic           o_rdy;
    logic [O_W-1:0] o_dat;
    logic           o_clip;

    modport master (
        output i_vld,
        output i_dat,
        output o_rdy,
        input  i_rdy,
        input  o_vld,
        input  o_dat,
        input  o_clip
    );

    modport slave (
        input  i_vld,
        input  i_dat,
        input  o_rdy,
        output i_rdy,
        output o_vld,
        output o_dat,
        output o_clip
    );
endinterface

// File: rtl/hgw_unsat_expand.sv
// ----------------------------------------------------------------------------
// hgw_unsat_expand
//
// Purpose: receive-side companion to the unsigned saturator. Widens a
// narrowed, saturated unsigned stream back to the wide datapath width, flags
// samples sitting at narrow full scale as clipped, keeps a saturating count
// of clipped samples and raises a sticky alarm once a run of consecutive
// clipped samples reaches RUN_TH.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : hgw_unsat_expand_if.slave (i_vld/i_rdy/i_dat in,
//              o_vld/o_rdy/o_dat/o_clip out)
//   clr      : synchronous clear of alarm, clip_cnt and the run counter
//   alarm    : sticky, a clipped run reached RUN_TH
//   clip_cnt : total clipped samples accepted, saturates at all ones
//
// Parameters:
//   I_W    : narrow width (>= 1)
//   O_W    : wide width (> I_W)
//   RUN_TH : consecutive clipped samples that set the alarm (>= 1)
//   CNT_W  : width of clip_cnt
//
// Build option:
//   HGW_UNSAT_RESTORE_EN : when defined, a clipped sample is widened to wide
//                          full scale instead of being zero-extended. Flags,
//                          counters and alarm are the same in both builds.
// ----------------------------------------------------------------------------
module hgw_unsat_expand #(
    parameter int I_W    = 15,
    parameter int O_W    = 16,
    parameter int RUN_TH = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    hgw_unsat_expand_if.slave bus,
    input  logic             clr,
    output logic             alarm,
    output logic [CNT_W-1:0] clip_cnt
);
    // Run counter only needs to reach RUN_TH, then it parks there.
    localparam int RUN_W = $clog2(RUN_TH + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RUN_TH);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_TH - 1);

    generate
        if (I_W < 1) begin : g_bad_i_w
            $error("hgw_unsat_expand: I_W must be >= 1");
        end
        if (O_W <= I_W) begin : g_bad_o_w
            $error("hgw_unsat_expand: O_W must be greater than I_W");
        end
        if (RUN_TH < 1) begin : g_bad_run_th
            $error("hgw_unsat_expand: RUN_TH must be >= 1");
        end
    endgenerate

    logic             accept;
    logic             clip_in;
    logic [O_W-1:0]   wide_dat;

    logic             o_vld_q;
    logic [O_W-1:0]   o_dat_q;
    logic             o_clip_q;
    logic [RUN_W-1:0] run_cnt;
    logic             alarm_q;
    logic [CNT_W-1:0] clip_cnt_q;

    // The output register may take a new sample whenever it is empty or is
    // being drained this cycle, so back-to-back streaming has no bubble.
    assign bus.i_rdy = ~o_vld_q | bus.o_rdy;
    assign accept    = bus.i_vld & bus.i_rdy;

    // A narrow sample at full scale is the saturator's clip marker.
    assign clip_in = &bus.i_dat;

`ifdef HGW_UNSAT_RESTORE_EN
    // Restore a clipped sample to wide full scale so downstream arithmetic
    // sees a saturated value rather than a mid-range one.
    always_comb begin
        wide_dat = {{(O_W - I_W){1'b0}}, bus.i_dat};
        if (clip_in) begin
            wide_dat = '1;
        end
    end
`else
    always_comb begin
        wide_dat = {{(O_W - I_W){1'b0}}, bus.i_dat};
    end
`endif

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_vld_q  <= 1'b0;
            o_dat_q  <= '0;
            o_clip_q <= 1'b0;
        end else if (accept) begin
            // Covers both a fill and a simultaneous drain-and-reload.
            o_vld_q  <= 1'b1;
            o_dat_q  <= wide_dat;
            o_clip_q <= clip_in;
        end else if (bus.o_rdy) begin
            o_vld_q  <= 1'b0;
        end
    end

    assign bus.o_vld  = o_vld_q;
    assign bus.o_dat  = o_dat_q;
    assign bus.o_clip = o_clip_q;

    // ------------------------------------------------------------------
    // Clip statistics: run counter, sticky alarm, total clip counter.
    // clr wins over a same-cycle clipped accept so software always sees a
    // clean zero after clearing.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt    <= '0;
            alarm_q    <= 1'b0;
            clip_cnt_q <= '0;
        end else if (clr) begin
            run_cnt    <= '0;
            alarm_q    <= 1'b0;
            clip_cnt_q <= '0;
        end else if (accept) begin
            if (clip_in) begin
                if (run_cnt != RUN_MAX) begin
                    run_cnt <= run_cnt + RUN_W'(1);
                end
                // This accept brings the run to RUN_TH (or it is already
                // there), so the alarm shows up with this sample's o_vld.
                if (run_cnt >= RUN_LAST) begin
                    alarm_q <= 1'b1;
                end
                if (clip_cnt_q != {CNT_W{1'b1}}) begin
                    clip_cnt_q <= clip_cnt_q + CNT_W'(1);
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

    assign alarm    = alarm_q;
    assign clip_cnt = clip_cnt_q;

endmodule

// File: tb/tb_hgw_unsat_expand.sv
// ----------------------------------------------------------------------------
// tb_hgw_unsat_expand
//
// Bench for hgw_unsat_expand. Two instances share one stimulus: the default
// configuration and one with a 3-bit clip counter to exercise saturation.
// Expected values come from a cycle-level reference model written in plain
// integer arithmetic plus an expected-output queue.
// ----------------------------------------------------------------------------
module tb_hgw_unsat_expand;
    localparam int I_W     = 15;
    localparam int O_W     = 16;
    localparam int RUN_TH  = 8;
    localparam int CNT_W   = 16;
    localparam int CNT_W_S = 3;
    localparam logic [I_W-1:0] FULL = {I_W{1'b1}};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic clr;
    always #5 clk = ~clk;

    logic               alarm;
    logic [CNT_W-1:0]   clip_cnt;
    logic               alarm_s;
    logic [CNT_W_S-1:0] clip_cnt_s;

    hgw_unsat_expand_if #(.I_W(I_W), .O_W(O_W)) bus ();
    hgw_unsat_expand_if #(.I_W(I_W), .O_W(O_W)) bus_s ();

    hgw_unsat_expand #(.I_W(I_W), .O_W(O_W), .RUN_TH(RUN_TH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .clr      (clr),
        .alarm    (alarm),
        .clip_cnt (clip_cnt)
    );

    hgw_unsat_expand #(.I_W(I_W), .O_W(O_W), .RUN_TH(RUN_TH), .CNT_W(CNT_W_S)) dut_s (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_s),
        .clr      (clr),
        .alarm    (alarm_s),
        .clip_cnt (clip_cnt_s)
    );

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [O_W-1:0] exp_q[$];

    bit             m_vld;
    logic [O_W-1:0] m_dat;
    bit             m_clip;
    int             m_run;
    int             m_total;
    bit             m_alarm;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [O_W-1:0] widen(input logic [I_W-1:0] d);
        int v;
        v = int'(d);
`ifdef HGW_UNSAT_RESTORE_EN
        if (v == (1 << I_W) - 1) return (O_W)'((1 << O_W) - 1);
`endif
        return (O_W)'(v);
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check_state();
        check("o_vld", bus.o_vld, m_vld);
        check("o_vld_s", bus_s.o_vld, m_vld);
        if (m_vld) begin
            check("o_dat", bus.o_dat, m_dat);
            check("o_clip", bus.o_clip, m_clip);
            check("o_dat_s", bus_s.o_dat, m_dat);
        end
        check("alarm", alarm, m_alarm);
        check("alarm_s", alarm_s, m_alarm);
        check("clip_cnt", clip_cnt, sat(m_total, CNT_W));
        check("clip_cnt_s", clip_cnt_s, sat(m_total, CNT_W_S));
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; drives one cycle of inputs and checks
    // the state that results after the next rising edge.
    task automatic cycle(input bit vld, input logic [I_W-1:0] dat, input bit ordy, input bit c);
        bit rdy;
        bit acc;
        bit clp;
        logic [O_W-1:0] head;
        bus.i_vld   = vld;
        bus.i_dat   = dat;
        bus.o_rdy   = ordy;
        bus_s.i_vld = vld;
        bus_s.i_dat = dat;
        bus_s.o_rdy = ordy;
        clr         = c;
        #4;
        rdy = !m_vld || ordy;
        check("i_rdy", bus.i_rdy, rdy);
        check("i_rdy_s", bus_s.i_rdy, rdy);
        if (m_vld && ordy) begin
            head = exp_q.pop_front();
            check("sb_o_dat", bus.o_dat, head);
        end
        acc = vld && rdy;
        clp = (int'(dat) == (1 << I_W) - 1);
        @(posedge clk);
        #1;
        if (acc) begin
            m_vld  = 1'b1;
            m_dat  = widen(dat);
            m_clip = clp;
            exp_q.push_back(m_dat);
        end else if (ordy) begin
            m_vld = 1'b0;
        end
        if (c) begin
            m_run   = 0;
            m_total = 0;
            m_alarm = 1'b0;
        end else if (acc && clp) begin
            m_run++;
            m_total++;
            if (m_run >= RUN_TH) m_alarm = 1'b1;
        end else if (acc) begin
            m_run = 0;
        end
        check_state();
    endtask

    task automatic do_reset();
        bus.i_vld   = 1'b0;
        bus.o_rdy   = 1'b0;
        bus_s.i_vld = 1'b0;
        bus_s.o_rdy = 1'b0;
        clr         = 1'b0;
        rst         = 1'b1;
        #1;
        m_vld   = 1'b0;
        m_dat   = '0;
        m_clip  = 1'b0;
        m_run   = 0;
        m_total = 0;
        m_alarm = 1'b0;
        exp_q.delete();
        check("rst_o_vld", bus.o_vld, 0);
        check("rst_o_dat", bus.o_dat, 0);
        check("rst_o_clip", bus.o_clip, 0);
        check("rst_alarm", alarm, 0);
        check("rst_clip_cnt", clip_cnt, 0);
        check("rst_clip_cnt_s", clip_cnt_s, 0);
        check("rst_i_rdy", bus.i_rdy, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [I_W-1:0] d;
        bit             v;
        bit             r;
        bit             c;
        int             p;

        rst = 1'b1;
        clr = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Plain zero-extension path.
        cycle(1, 15'h0000, 1, 0);
        check("dir_dat0", bus.o_dat, 16'h0000);
        cycle(1, 15'h0001, 1, 0);
        check("dir_dat1", bus.o_dat, 16'h0001);
        cycle(1, 15'h3FFE, 1, 0);
        check("dir_dat3ffe", bus.o_dat, 16'h3FFE);
        check("dir_clip0", bus.o_clip, 0);
        cycle(0, 15'h0000, 1, 0);
        check("dir_cnt0", clip_cnt, 0);

        // Run of RUN_TH clipped samples sets the alarm.
        for (int i = 0; i < RUN_TH; i++) begin
            cycle(1, FULL, 1, 0);
            if (i == RUN_TH - 2) check("alarm_pre", alarm, 0);
        end
        check("alarm_run8", alarm, 1);
        check("cnt_run8", clip_cnt, 8);
`ifdef HGW_UNSAT_RESTORE_EN
        check("dat_run8", bus.o_dat, 16'hFFFF);
`else
        check("dat_run8", bus.o_dat, 16'h7FFF);
`endif
        cycle(0, 15'h0000, 1, 1);

        // Broken runs never reach the threshold.
        for (int i = 0; i < 7; i++) cycle(1, FULL, 1, 0);
        cycle(1, 15'h0001, 1, 0);
        for (int i = 0; i < 7; i++) cycle(1, FULL, 1, 0);
        check("alarm_7_1_7", alarm, 0);
        check("cnt_7_1_7", clip_cnt, 14);
        cycle(0, 15'h0000, 1, 1);

        // Backpressure: one sample held while downstream stalls.
        cycle(1, 15'h0005, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 15'h0006, 0, 0);
            check("bp_hold", bus.o_dat, 16'h0005);
        end
        cycle(1, 15'h0006, 1, 0);
        check("bp_reload", bus.o_dat, 16'h0006);
        cycle(0, 15'h0000, 1, 0);
        check("bp_drained", bus.o_vld, 0);

        // Clip counter saturation on the narrow-counter instance.
        cycle(0, 15'h0000, 1, 1);
        for (int i = 0; i < 10; i++) cycle(1, FULL, 1, 0);
        check("cnt_sat_s", clip_cnt_s, 7);
        check("cnt_10", clip_cnt, 10);

        // clr together with a clipped accept: counters zero, data still flows.
        cycle(1, FULL, 1, 1);
        check("clr_alarm", alarm, 0);
        check("clr_cnt", clip_cnt, 0);
        check("clr_o_clip", bus.o_clip, 1);
        check("clr_o_vld", bus.o_vld, 1);
        for (int i = 0; i < RUN_TH - 1; i++) cycle(1, FULL, 1, 0);
        check("clr_run_zero", alarm, 0);
        cycle(1, FULL, 1, 0);
        check("clr_run_alarm", alarm, 1);
        cycle(0, 15'h0000, 1, 1);

        // Randomized traffic in blocks of high and low clip density.
        for (int b = 0; b < 30; b++) begin
            p = (b % 2 == 1) ? 90 : 20;
            for (int i = 0; i < 15; i++) begin
                v = ($urandom_range(0, 99) < 80);
                r = ($urandom_range(0, 99) < 75);
                c = ($urandom_range(0, 99) < 2);
                if ($urandom_range(0, 99) < p) d = FULL;
                else d = I_W'($urandom_range(0, (1 << I_W) - 2));
                cycle(v, d, r, c);
            end
        end

        // Reset while a sample sits in the output register.
        cycle(1, 15'h0003, 0, 0);
        cycle(1, FULL, 0, 0);
        check("pre_rst_vld", bus.o_vld, 1);
        do_reset();
        cycle(1, 15'h0007, 1, 0);
        cycle(0, 15'h0000, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
